// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive and transmit paths.
//   - uart_rx_state_e : 2-bit receiver state encoding (IDLE/START/DATA/STOP),
//                       identical to the transmitter state encoding.
//   - OVERSAMPLE_DEF  : default number of rx_clk_en pulses per bit period.
//   - DATA_BITS_DEF   : default number of data bits per frame.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        UART_RX_IDLE  = 2'd0,
        UART_RX_START = 2'd1,
        UART_RX_DATA  = 2'd2,
        UART_RX_STOP  = 2'd3
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous, idle-high input.
// Both flops reset to 1 so an idle line never looks like a start bit while
// the chain refills after reset.
// Ports:
//   clk  : destination clock
//   rst  : asynchronous, active-high reset (flops forced to 1)
//   din  : asynchronous input
//   dout : synchronized copy of din, two clk cycles of latency
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with 16x oversampling.
// A falling edge on the synchronized line starts a frame; the start bit is
// re-checked at its middle, each data bit is sampled one bit period later
// (mid-bit), then the stop bit decides between storing the byte and flagging
// a framing error.
//
// Handshake: rx_valid is a level meaning "rx_data not yet consumed". The
// consumer raises rx_ack for a cycle while rx_valid is high; rx_valid drops
// on the following cycle. A byte stored in the same cycle as rx_ack wins and
// keeps rx_valid high. Storing a byte while rx_valid is high and unacked
// overwrites rx_data and pulses rx_overrun.
//
// Ports:
//   sys_clk      : system clock, rising edge
//   rst          : asynchronous, active-high reset
//   rx_clk_en    : one-cycle pulse at OVERSAMPLE x baud
//   uart_rx      : asynchronous serial input, idle high
//   rx_ack       : consumer takes rx_data this cycle
//   rx_data      : last good byte, held until the next good frame
//   rx_valid     : rx_data unread
//   rx_busy      : receiver not idle
//   rx_frame_err : one-cycle pulse, stop bit sampled low
//   rx_overrun   : one-cycle pulse, good frame landed on an unread byte
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 rx_clk_en,
    input  logic                 uart_rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_rx_state_e        state;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  rx_s;

    uart_rx_sync u_sync (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (uart_rx),
        .dout (rx_s)
    );

    assign rx_busy = (state != UART_RX_IDLE);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state        <= UART_RX_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;

            // Consumer ack clears the flag; a store later in this block
            // overrides it so a same-cycle new byte is never lost.
            if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (rx_clk_en) begin
                case (state)
                    UART_RX_IDLE: begin
                        if (!rx_s) begin
                            state    <= UART_RX_START;
                            tick_cnt <= '0;
                        end
                    end

                    UART_RX_START: begin
                        if (tick_cnt == TICK_MID) begin
                            if (!rx_s) begin
                                state    <= UART_RX_DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                // Line came back high: a glitch, not a frame.
                                state    <= UART_RX_IDLE;
                                tick_cnt <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    UART_RX_DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            // LSB arrives first, so shift in from the top.
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= UART_RX_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    UART_RX_STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            state    <= UART_RX_IDLE;
                            tick_cnt <= '0;
                            if (rx_s) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                                if (rx_valid && !rx_ack) begin
                                    rx_overrun <= 1'b1;
                                end
                            end else begin
                                rx_frame_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state    <= UART_RX_IDLE;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive path: recovers 8N1 frames from the asynchronous uart_rx pin and presents bytes on a valid/ack handshake.
- Counterpart of uart_transmitter; shares the same sys_clk domain.
- Uses a 16x-oversampling enable pulse (rx_clk_en) from the shared baud generator.
- Flags framing errors and overruns.

Parameters:
- OVERSAMPLE, 16, rx_clk_en pulses per bit period; power of two, at least 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_clk_en  input  1  single-cycle pulse at OVERSAMPLE x baud.
- uart_rx  input  1  serial line, asynchronous, idle high.
- rx_ack  input  1  consumer accepts rx_data this cycle.
- rx_data  output  DATA_BITS  last good byte; held until the next good frame.
- rx_valid  output  1  rx_data unread; level signal.
- rx_busy  output  1  high when state != IDLE.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  output  1  one-cycle pulse: good frame completed while rx_valid was already high.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, counters=0.
  - Synchronizer flops=1.
  - rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0.
- Synchronizer: uart_rx passes through 2 flops (rx_s); all decisions use rx_s. Pin-to-rx_s latency is 2 cycles.
- tick_cnt (log2 OVERSAMPLE bits) advances only on rx_clk_en, wraps to 0. bit_cnt counts data bits.
- States:
  - IDLE: when rx_s=0 is seen on an rx_clk_en cycle, go to START with tick_cnt=0.
  - START: on the rx_clk_en where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rx_s=1: glitch; return to IDLE with no flag.
  - DATA: on each rx_clk_en where tick_cnt==OVERSAMPLE-1, shift rx_s into shreg MSB (right shift, LSB first). After DATA_BITS samples go to STOP with tick_cnt reset.
  - STOP: on rx_clk_en where tick_cnt==OVERSAMPLE-1:
    - rx_s=1 (good frame): rx_data<=shreg, rx_valid<=1. If rx_valid was already 1 and rx_ack is low that cycle, pulse rx_overrun; the new byte overwrites the old one.
    - rx_s=0: pulse rx_frame_err; rx_data and rx_valid unchanged.
    - Either way, return to IDLE next cycle.
  - Illegal state encoding: go to IDLE.
- Handshake:
  - rx_valid clears the cycle after rx_ack is sampled high.
  - rx_ack and a good-frame store in the same cycle: store wins, rx_valid stays 1, no overrun.
  - rx_ack while rx_valid=0 is ignored.
- Break condition (line held low): frame error, then rx_s=0 re-arms START on the next rx_clk_en. Back-to-back errors are acceptable.
- rx_clk_en low: no state or counter advance.
- Outputs are registered; the rx_valid rise follows the stop-sample edge by one cycle.

Decomposition:
- Package uart_pkg:
  - State constants UART_RX_IDLE/START/DATA/STOP, 2 bits, same encodings as the transmitter states.
  - OVERSAMPLE default.
- Sub-module uart_rx_sync: 2-flop synchronizer with async reset to 1. Reused for other async inputs.

Test Plan:
- Stimulus for all scenarios: baud = 16 rx_clk_en periods; rx_clk_en every 4 sys_clk.
- Frame 0x55 (start, 1,0,1,0,1,0,1,0, stop) -> rx_data=0x55, rx_valid=1, no error pulses; rx_ack clears rx_valid next cycle.
- Frames 0xA5 then 0x3C back-to-back, rx_ack held high -> two valid updates in order, rx_overrun never pulses.
- 0x00 with stop bit driven low -> one-cycle rx_frame_err; rx_data keeps the prior value, rx_valid unchanged.
- 4-tick low glitch on idle line -> busy briefly, then IDLE; no valid, no error.
- 0x12 not acked, then 0x34 -> rx_overrun pulse, rx_data=0x34, rx_valid=1.
- Assert rst during DATA of 0xFF -> all outputs 0 immediately; the next clean 0x81 frame is received correctly.
